// File: rtl/weight_add_trans.sv
// Computes d = W^T * e for a 2x4 Q2.14 weight matrix using one shared 16x16 multiplier.
// Latency: start accepted at edge k -> result_valid high in the cycle after edge k+8.
// Backpressure: none; en is ignored while busy, result_valid is a one-cycle pulse.
module weight_add_trans #(
    parameter int FRAC = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] w11,
    input  logic [15:0] w12,
    input  logic [15:0] w13,
    input  logic [15:0] w14,
    input  logic [15:0] w21,
    input  logic [15:0] w22,
    input  logic [15:0] w23,
    input  logic [15:0] w24,
    input  logic [15:0] e1,
    input  logic [15:0] e2,
    output logic        busy,
    output logic        result_valid,
    output logic [15:0] out1,
    output logic [15:0] out2,
    output logic [15:0] out3,
    output logic [15:0] out4
);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [2:0]         step_q;
    logic signed [18:0] acc_q;
    logic        [15:0] out_q [4];
    logic               valid_q;

    // Weights stored in step order: slot s holds w1j for even s, w2j for odd s.
    logic signed [15:0] w_q [8];
    logic signed [15:0] e1_q;
    logic signed [15:0] e2_q;

    logic               start;
    logic signed [15:0] mul_a;
    logic signed [15:0] mul_b;
    logic signed [31:0] prod;
    logic signed [18:0] prod_ext;
    logic signed [18:0] sum;
    logic        [15:0] sat_val;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    start   = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (step_q == 3'd7) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single shared multiplier; the shift floors because prod is signed.
    always_comb begin
        mul_a    = w_q[step_q];
        mul_b    = step_q[0] ? e2_q : e1_q;
        prod     = 32'(mul_a) * 32'(mul_b);
        prod_ext = 19'(prod >>> FRAC);
        sum      = acc_q + prod_ext;
        if (sum > 19'sd32767) begin
            sat_val = 16'h7FFF;
        end else if (sum < -19'sd32768) begin
            sat_val = 16'h8000;
        end else begin
            sat_val = sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= 3'd0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            e1_q    <= '0;
            e2_q    <= '0;
            for (int i = 0; i < 8; i++) begin
                w_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            valid_q <= 1'b0;
            if (start) begin
                w_q[0] <= w11;
                w_q[1] <= w21;
                w_q[2] <= w12;
                w_q[3] <= w22;
                w_q[4] <= w13;
                w_q[5] <= w23;
                w_q[6] <= w14;
                w_q[7] <= w24;
                e1_q   <= e1;
                e2_q   <= e2;
                step_q <= 3'd0;
                acc_q  <= '0;
            end else if (state_q == CALC) begin
                step_q <= step_q + 3'd1;
                if (step_q[0]) begin
                    out_q[step_q[2:1]] <= sat_val;
                    acc_q              <= '0;
                    if (step_q == 3'd7) begin
                        valid_q <= 1'b1;
                    end
                end else begin
                    acc_q <= sum;
                end
            end
        end
    end

    assign busy         = (state_q == CALC);
    assign result_valid = valid_q;
    assign out1         = out_q[0];
    assign out2         = out_q[1];
    assign out3         = out_q[2];
    assign out4         = out_q[3];

endmodule

// File: tb/tb_weight_add_trans.sv
// Randomized and directed checks of weight_add_trans against an arithmetic reference model.
module tb_weight_add_trans;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] wm [2][4];
    logic [15:0] e1;
    logic [15:0] e2;
    logic        busy;
    logic        result_valid;
    logic [15:0] out1;
    logic [15:0] out2;
    logic [15:0] out3;
    logic [15:0] out4;

    int          n_cmp;
    int          n_err;
    logic [15:0] model_out [4];
    logic [15:0] exp_out [4];

    weight_add_trans #(.FRAC(14)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .w11          (wm[0][0]),
        .w12          (wm[0][1]),
        .w13          (wm[0][2]),
        .w14          (wm[0][3]),
        .w21          (wm[1][0]),
        .w22          (wm[1][1]),
        .w23          (wm[1][2]),
        .w24          (wm[1][3]),
        .e1           (e1),
        .e2           (e2),
        .busy         (busy),
        .result_valid (result_valid),
        .out1         (out1),
        .out2         (out2),
        .out3         (out3),
        .out4         (out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] get_out(input int j);
        case (j)
            0:       return out1;
            1:       return out2;
            2:       return out3;
            default: return out4;
        endcase
    endfunction

    // out_j = sat16(floor(w1j*e1 / 2^14) + floor(w2j*e2 / 2^14))
    function automatic logic [15:0] ref_out(input logic [15:0] a1, input logic [15:0] a2,
                                            input logic [15:0] b1, input logic [15:0] b2);
        longint x1, x2, y1, y2, s;
        x1 = longint'($signed(a1));
        x2 = longint'($signed(a2));
        y1 = longint'($signed(b1));
        y2 = longint'($signed(b2));
        s  = ((x1 * y1) >>> 14) + ((x2 * y2) >>> 14);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [15:0] wv, input logic [15:0] ev1, input logic [15:0] ev2);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                wm[r][c] = wv;
        e1 = ev1;
        e2 = ev2;
    endtask

    function automatic logic [15:0] rand_val();
        int sel;
        sel = $urandom_range(0, 5);
        case (sel)
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Starts an operation with the currently driven data, then scrambles the
    // inputs and checks busy/result_valid and per-column output updates.
    task automatic run_op(input string name);
        logic [15:0] want;
        for (int j = 0; j < 4; j++)
            exp_out[j] = ref_out(wm[0][j], wm[1][j], e1, e2);
        en = 1'b1;
        step();
        en = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                wm[r][c] = 16'($urandom);
        e1 = 16'($urandom);
        e2 = 16'($urandom);
        chk({name, "_busy0"}, 32'(busy), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 3) en = 1'b1;
            if (i == 4) en = 1'b0;
            chk($sformatf("%s_busy%0d", name, i), 32'(busy), (i < 8) ? 32'd1 : 32'd0);
            chk($sformatf("%s_rv%0d", name, i), 32'(result_valid), (i == 8) ? 32'd1 : 32'd0);
            for (int j = 0; j < 4; j++) begin
                want = (i >= 2 * (j + 1)) ? exp_out[j] : model_out[j];
                chk($sformatf("%s_out%0d_c%0d", name, j + 1, i), 32'(get_out(j)), 32'(want));
            end
        end
        for (int j = 0; j < 4; j++)
            model_out[j] = exp_out[j];
        step();
        chk({name, "_rv_off"}, 32'(result_valid), 32'd0);
        for (int j = 0; j < 4; j++)
            chk($sformatf("%s_hold%0d", name, j + 1), 32'(get_out(j)), 32'(model_out[j]));
    endtask

    initial begin
        int pulses;
        int last_pulse;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        set_all(16'h0000, 16'h0000, 16'h0000);
        for (int j = 0; j < 4; j++)
            model_out[j] = 16'h0000;
        step();
        en = 1'b1;
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        for (int j = 0; j < 4; j++)
            chk($sformatf("rst_out%0d", j + 1), 32'(get_out(j)), 32'd0);
        en    = 1'b0;
        rst_n = 1'b1;
        step();

        set_all(16'h4000, 16'h2000, 16'h2000);
        run_op("unity");
        set_all(16'h7FFF, 16'h7FFF, 16'h7FFF);
        run_op("satpos");
        set_all(16'h8000, 16'h7FFF, 16'h7FFF);
        run_op("satneg");

        set_all(16'h0000, 16'h2000, 16'h2000);
        wm[0][0] = 16'h4000; wm[1][0] = 16'hC000;
        wm[0][1] = 16'h2000; wm[1][1] = 16'h2000;
        wm[0][2] = 16'hC000; wm[1][2] = 16'hC000;
        wm[0][3] = 16'h0000; wm[1][3] = 16'h7FFF;
        run_op("sign");
        chk("sign_ref1", 32'(model_out[0]), 32'h0000);
        chk("sign_ref4", 32'(model_out[3]), 32'h3FFF);

        set_all(16'h0000, 16'h0001, 16'h0000);
        wm[0][0] = 16'h0001;
        wm[0][1] = 16'hFFFF;
        run_op("trunc");

        for (int n = 0; n < 30; n++) begin
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 4; c++)
                    wm[r][c] = rand_val();
            e1 = rand_val();
            e2 = rand_val();
            run_op($sformatf("rnd%0d", n));
        end

        // Reset at the 4th CALC edge aborts without a pulse.
        set_all(16'h4000, 16'h2000, 16'h2000);
        en = 1'b1;
        step();
        en = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        en    = 1'b1;
        step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rv", 32'(result_valid), 32'd0);
        for (int j = 0; j < 4; j++)
            chk($sformatf("abort_out%0d", j + 1), 32'(get_out(j)), 32'd0);
        step();
        chk("abort_en_in_rst", 32'(busy), 32'd0);
        for (int j = 0; j < 4; j++)
            model_out[j] = 16'h0000;
        rst_n = 1'b1;
        en    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (result_valid) pulses++;
        end
        chk("abort_no_pulse", 32'(pulses), 32'd0);
        run_op("after_abort");

        // en held high: starts only in IDLE, pulses 9 cycles apart.
        set_all(16'h4000, 16'h2000, 16'h2000);
        en         = 1'b1;
        pulses     = 0;
        last_pulse = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (result_valid) begin
                pulses++;
                chk($sformatf("hs_gap%0d", pulses), 32'(i - last_pulse),
                    (pulses == 1) ? 32'd9 : 32'd9);
                last_pulse = i;
                for (int j = 0; j < 4; j++)
                    chk($sformatf("hs_out%0d_p%0d", j + 1, pulses), 32'(get_out(j)), 32'h4000);
            end
        end
        chk("hs_pulses", 32'(pulses), 32'd4);
        en = 1'b0;
        for (int i = 0; i < 10; i++)
            step();
        chk("hs_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/weight_add_trans.md
WEIGHT_ADD_TRANS -- requirements
Module: weight_add_trans

Interface
REQ-001 SHALL have parameter FRAC, default 14, meaning the number of fractional bits of the signed Q2.14 fixed-point format used on all data ports.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: the reset; it is synchronous and active-low.
REQ-004 SHALL have port en, input, 1 bit: start request, sampled only in IDLE.
REQ-005 SHALL have ports w11, w12, w13, w14, w21, w22, w23, w24, each input, 16 bits: signed 2x4 weight matrix W, with row index first.
REQ-006 SHALL have ports e1 and e2, each input, 16 bits: signed error/input vector e.
REQ-007 SHALL have port busy, output, 1 bit: high while a computation is in progress.
REQ-008 SHALL have port result_valid, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have ports out1, out2, out3, out4, each output, 16 bits: signed result vector d = W^T * e, where out_j = w1j*e1 + w2j*e2.

Function
REQ-010 SHALL implement FSM states IDLE and CALC.
REQ-011 In IDLE with en=1 at an edge, SHALL capture all eight weights and e1/e2 into internal registers, clear the step counter and accumulator, and enter CALC.
REQ-012 SHALL ignore later changes on the data inputs until the next accepted start.
REQ-013 SHALL use exactly one 16x16 signed multiplier, time-multiplexed over 8 CALC steps s=0..7.
- Step s=2(j-1) computes w1j*e1.
- Step s=2(j-1)+1 computes w2j*e2.
REQ-014 Each product SHALL be the full 32-bit signed product, arithmetically shifted right by FRAC (truncation toward minus infinity), then sign-extended into a 19-bit signed accumulator.
REQ-015 On each odd step, the accumulator sum SHALL be saturated to 16 bits, written to out_j, and the accumulator cleared.
- Saturation bounds: above 32767 gives 0x7FFF; below -32768 gives 0x8000.
REQ-016 After step 7, the FSM SHALL return to IDLE, and result_valid SHALL be high for exactly the one cycle after that edge.
- Start accepted at edge k gives result_valid high in the cycle following edge k+8.
REQ-017 busy SHALL be high exactly while in CALC (8 cycles per operation).
REQ-018 en SHALL be ignored while busy=1; no queuing.
REQ-019 en=1 in the cycle result_valid is high (state IDLE) SHALL be accepted, giving back-to-back operations every 9 cycles.
REQ-020 out1..out4 SHALL hold their values between completions.
- They update only on their own odd step, so during CALC, outputs already written by the current operation may be new while the rest still hold the previous operation's values.
REQ-021 No arithmetic wrap SHALL occur anywhere; the 19-bit accumulator covers the extreme sum of 131072.

Reset
REQ-022 While rst_n=0 at an edge, the block SHALL set: state IDLE, counter 0, accumulator 0, busy 0, result_valid 0, out1..out4 0x0000, and operand registers 0.
REQ-023 Reset asserted mid-CALC SHALL abort the operation with no result_valid pulse.
REQ-024 en sampled in the same edge as rst_n=0 SHALL be ignored.

Verification
REQ-025 All w=0x4000 (1.0), e1=e2=0x2000 (0.5), en pulsed at edge k -> busy high for 8 cycles, result_valid in the cycle after edge k+8, out1..out4=0x4000.
REQ-026 Positive saturation: all w=0x7FFF, e1=e2=0x7FFF -> each product 0xFFFC (65532), sum 131064 -> out1..out4=0x7FFF.
- Negative saturation: all w=0x8000, e1=e2=0x7FFF -> out1..out4=0x8000.
REQ-027 Sign and mixed-sign cases, e1=e2=0x2000, with:
- w11=0x4000, w21=0xC000 -> out1=0x0000.
- w12=0x2000, w22=0x2000 -> out2=0x2000.
- w13=0xC000, w23=0xC000 -> out3=0xC000.
- w14=0x0000, w24=0x7FFF -> out4=0x3FFF.
REQ-028 Truncation: e1=0x0001, e2=0x0000, w11=0x0001, w12=0xFFFF, other w=0 -> out1=0x0000, out2=0xFFFF (floor), out3=out4=0x0000.
REQ-029 Reset mid-operation: start, drive rst_n=0 at the 4th CALC edge -> next cycle busy=0, outputs 0x0000, no result_valid.
- A following start then completes normally.
REQ-030 Handshake: en held high continuously with the REQ-025 data -> a start is accepted only in IDLE, giving result_valid pulses exactly 9 cycles apart.
- en pulses during busy produce no extra pulse and do not disturb out values.
